// File: rtl/tff_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tff_pkg
// Brief    : Shared constants for the toggle flip-flop leaf cell.
// Revision : 1.0 - initial release
// ============================================================================
package tff_pkg;

    // State forced by the asynchronous clear control
    localparam logic c_clear_value  = 1'b0;
    // State forced by the asynchronous preset control
    localparam logic c_preset_value = 1'b1;

endpackage : tff_pkg
`default_nettype wire

// File: rtl/tff_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tff_if
// Brief    : Signal bundle for the toggle flip-flop: toggle enable, async
//            preset and the complementary state outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface tff_if;

    logic t;        // toggle enable, sampled on rising clk
    logic preset;   // asynchronous active-high set
    logic q;        // registered state
    logic qbar;     // complement of q

    // Driver side (counter/divider logic or a testbench)
    modport master (
        output t,
        output preset,
        input  q,
        input  qbar
    );

    // Flip-flop side
    modport slave (
        input  t,
        input  preset,
        output q,
        output qbar
    );

endinterface : tff_if
`default_nettype wire

// File: rtl/tff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tff
// Brief    : Single-bit toggle flip-flop with asynchronous clear (highest
//            priority) and asynchronous preset, plus complementary outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tff
    import tff_pkg::*;
(
    input  wire logic clk,
    input  wire logic clear,
    tff_if.slave      bus
);

    logic r_state;

    // Single state bit: clear beats preset, preset beats the clocked toggle
    always_ff @(posedge clk or posedge clear or posedge bus.preset) begin
        if (clear) begin
            r_state <= c_clear_value;
        end else if (bus.preset) begin
            r_state <= c_preset_value;
        end else if (bus.t) begin
            r_state <= ~r_state;
        end
    end

    // Both outputs come from the one state bit so they can never agree
    assign bus.q    = r_state;
    assign bus.qbar = ~r_state;

endmodule : tff
`default_nettype wire

// File: tb/tb_tff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tff
// Brief    : Self-checking bench for tff with a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tff;

    logic clk = 1'b0;
    logic clear;

    tff_if bus();

    tff dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    // 10 ns clock, rising edges at 7, 17, 27 ... so the scripted control
    // changes at 25/275/775 ns fall between edges
    initial begin
        #2;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic  exp_q;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: state = last forced value XOR parity of accepted toggles
    logic        base    = 1'b0;
    int unsigned flips   = 0;
    bit          defined = 1'b0;

    function automatic logic model_q();
        return base ^ flips[0];
    endfunction

    task automatic push(input string tag);
        exp_t e;
        if (defined) begin
            e.exp_q = model_q();
            e.tag   = tag;
            sb.push_back(e);
        end
    endtask

    // Force a new state (assert clear or preset) and record it
    task automatic force_state(input logic c, input logic p, input string tag);
        clear      = c;
        bus.preset = p;
        if (c) begin
            base = 1'b0; flips = 0; defined = 1'b1;
        end else if (p) begin
            base = 1'b1; flips = 0; defined = 1'b1;
        end
        push(tag);
    endtask

    // Wait for one rising edge and predict its effect
    task automatic tick(input string tag);
        @(posedge clk);
        if (!clear && !bus.preset && bus.t)
            flips++;
        push(tag);
    endtask

    // Monitor: compare each queued expectation 1 ns after it appears
    initial begin
        exp_t e;
        forever begin
            wait (sb.size() != 0);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.q !== e.exp_q) begin
                    errors++;
                    $display("FAIL %s q: got %b expected %b at %0t", e.tag, bus.q, e.exp_q, $time);
                end
                checks++;
                if (bus.qbar !== ~e.exp_q) begin
                    errors++;
                    $display("FAIL %s qbar: got %b expected %b at %0t", e.tag, bus.qbar, ~e.exp_q, $time);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int r;
        clear      = 1'b0;
        bus.preset = 1'b0;
        bus.t      = 1'b0;

        // Preset at 25 ns, then clocks with random t must not disturb it
        #25;
        force_state(1'b0, 1'b1, "preset");
        repeat (25) begin
            bus.t = 1'($urandom);
            tick("preset_hold");
        end
        #8;

        // Clear on top of preset at 275 ns: clear wins for 500 ns
        force_state(1'b1, 1'b1, "clear_priority");
        repeat (50) begin
            bus.t = 1'($urandom);
            tick("clear_hold");
        end
        #8;

        // Release both at 775 ns with t driven low first
        bus.t      = 1'b0;
        clear      = 1'b0;
        bus.preset = 1'b0;
        push("release");
        repeat (10) tick("hold_t0");

        // Continuous toggling: f_clk/2 square wave
        #3 bus.t = 1'b1;
        repeat (20) tick("toggle");

        // Freeze, then resume from the frozen value
        #3 bus.t = 1'b0;
        repeat (5) tick("freeze");
        #3 bus.t = 1'b1;
        repeat (7) tick("resume");

        // 3 ns clear pulse mid-cycle while toggling
        #3;
        force_state(1'b1, 1'b0, "async_clear");
        #3;
        clear = 1'b0;
        push("async_clear_release");
        repeat (4) tick("after_clear");

        // 3 ns preset pulse mid-cycle while toggling
        #3;
        force_state(1'b0, 1'b1, "async_preset");
        #3;
        bus.preset = 1'b0;
        push("async_preset_release");
        repeat (4) tick("after_preset");

        // Randomised: random t each cycle, occasional mid-cycle control pulses
        repeat (200) begin
            tick("rand_edge");
            #3;
            r = int'($urandom_range(0, 7));
            if (r == 0) begin
                force_state(1'b1, 1'b0, "rand_clear");
                #3 clear = 1'b0;
                push("rand_clear_release");
            end else if (r == 1) begin
                force_state(1'b0, 1'b1, "rand_preset");
                #3 bus.preset = 1'b0;
                push("rand_preset_release");
            end else begin
                #3;
            end
            bus.t = 1'($urandom);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            #1;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tff
`default_nettype wire
